cararrow_sequencer: RTL and testbench

- Downstream consumer of the slow square wave produced by the 1 Hz clock-divider stage.
- Drives the six turn-signal lamps of the car-arrow display: three left, three right.
- Runs entirely on the fast board clock clk_in.
- Turns each rising edge of the divided clock into a one-cycle step tick, then advances a Thunderbird-style Moore FSM on that tick.
- Left, right and hazard switches are synchronised into clk_in.

---
 rtl/cararrow_sequencer.sv | 163 ++++++++++++++++
 tb/tb_cararrow_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cararrow_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cararrow_sequencer
//
// Turns the slow square wave from the 1 Hz divider into single-cycle step ticks.
// On each tick it advances a Thunderbird-style turn-signal sequencer that drives
// six arrow lamps, three on the left and three on the right. Everything runs on
// the fast board clock clk_in. The step clock and the three switches arrive
// asynchronously, so each one is synchronised into clk_in first.
//
// Ports:
//   clk_in     in   board clock (50 MHz)
//   rst        in   asynchronous, active-low reset
//   step_clk   in   divided clock; each rising edge advances the sequence one step
//   left       in   left-turn switch (level)
//   right      in   right-turn switch (level)
//   hazard     in   hazard switch (level)
//   lights_l   out  left lamps;  bit0 innermost, bit2 outermost
//   lights_r   out  right lamps; bit0 innermost, bit2 outermost
//   state_dbg  out  current FSM state code
//   busy       out  high whenever the FSM is not in IDLE
//
// SYNC_STAGES sets the synchroniser depth. Legal values are 2..4.
// -----------------------------------------------------------------------------
//  state | meaning
//  IDLE  | all lamps dark, waiting for a request on a tick
//  L1    | left sweep, inner lamp lit
//  L2    | left sweep, inner two lamps lit
//  L3    | left sweep, all three lamps lit
//  R1    | right sweep, inner lamp lit
//  R2    | right sweep, inner two lamps lit
//  R3    | right sweep, all three lamps lit
//  HAZ   | all six lamps lit; returns to IDLE on the next tick
// -----------------------------------------------------------------------------
module cararrow_sequencer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       step_clk,
  input  logic       left,
  input  logic       right,
  input  logic       hazard,
  output logic [2:0] lights_l,
  output logic [2:0] lights_r,
  output logic [2:0] state_dbg,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_L1   = 3'd1,
    ST_L2   = 3'd2,
    ST_L3   = 3'd3,
    ST_R1   = 3'd4,
    ST_R2   = 3'd5,
    ST_R3   = 3'd6,
    ST_HAZ  = 3'd7
  } state_e;

  // Synchronisers. Bit 0 of each chain is the first flop; the top bit is
  // the value that the rest of the logic uses.
  logic [SYNC_STAGES-1:0] sync_step_q;
  logic [SYNC_STAGES-1:0] sync_l_q;
  logic [SYNC_STAGES-1:0] sync_r_q;
  logic [SYNC_STAGES-1:0] sync_h_q;
  logic                   p_step_q;

  logic s_step;
  logic tick;
  logic req_l;
  logic req_r;
  logic req_h;

  state_e state_q;
  state_e state_d;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      sync_step_q <= '0;
      sync_l_q    <= '0;
      sync_r_q    <= '0;
      sync_h_q    <= '0;
      p_step_q    <= 1'b0;
    end else begin
      sync_step_q <= {sync_step_q[SYNC_STAGES-2:0], step_clk};
      sync_l_q    <= {sync_l_q[SYNC_STAGES-2:0], left};
      sync_r_q    <= {sync_r_q[SYNC_STAGES-2:0], right};
      sync_h_q    <= {sync_h_q[SYNC_STAGES-2:0], hazard};
      p_step_q    <= s_step;
    end
  end

  assign s_step = sync_step_q[SYNC_STAGES-1];
  assign req_l  = sync_l_q[SYNC_STAGES-1];
  assign req_r  = sync_r_q[SYNC_STAGES-1];
  assign req_h  = sync_h_q[SYNC_STAGES-1];

  // Rising-edge detect on the synchronised step clock. The history flop is
  // cleared by reset, so a step clock that is already high at reset release
  // produces one tick.
  assign tick = s_step & ~p_step_q;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          // A request for both sides at once is treated as a hazard request.
          if (req_h || (req_l && req_r)) state_d = ST_HAZ;
          else if (req_l)                state_d = ST_L1;
          else if (req_r)                state_d = ST_R1;
          else                           state_d = ST_IDLE;
        end
        // Once a sweep has started it always finishes, even if its switch
        // drops. Only hazard can cut it short.
        ST_L1:   state_d = req_h ? ST_HAZ : ST_L2;
        ST_L2:   state_d = req_h ? ST_HAZ : ST_L3;
        ST_L3:   state_d = req_h ? ST_HAZ : ST_IDLE;
        ST_R1:   state_d = req_h ? ST_HAZ : ST_R2;
        ST_R2:   state_d = req_h ? ST_HAZ : ST_R3;
        ST_R3:   state_d = req_h ? ST_HAZ : ST_IDLE;
        // Passing through IDLE gives the hazard blink its off step.
        ST_HAZ:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Moore decode taken straight from the state register, with no extra stage.
  always_comb begin
    lights_l = 3'b000;
    lights_r = 3'b000;
    case (state_q)
      ST_L1:   lights_l = 3'b001;
      ST_L2:   lights_l = 3'b011;
      ST_L3:   lights_l = 3'b111;
      ST_R1:   lights_r = 3'b001;
      ST_R2:   lights_r = 3'b011;
      ST_R3:   lights_r = 3'b111;
      ST_HAZ: begin
        lights_l = 3'b111;
        lights_r = 3'b111;
      end
      default: begin
        lights_l = 3'b000;
        lights_r = 3'b000;
      end
    endcase
  end

  assign state_dbg = state_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cararrow_sequencer.sv
`timescale 1ns/1ps
module tb_cararrow_sequencer;
  localparam int SYNC = 2;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       step_clk = 1'b0;
  logic       left = 1'b0;
  logic       right = 1'b0;
  logic       hazard = 1'b0;
  logic [2:0] lights_l;
  logic [2:0] lights_r;
  logic [2:0] state_dbg;
  logic       busy;

  int checks = 0;
  int errors = 0;

  cararrow_sequencer #(.SYNC_STAGES(SYNC)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .step_clk  (step_clk),
    .left      (left),
    .right     (right),
    .hazard    (hazard),
    .lights_l  (lights_l),
    .lights_r  (lights_r),
    .state_dbg (state_dbg),
    .busy      (busy)
  );

  always #10 clk_in = ~clk_in;

  // Reference model. Each input sample is delayed by SYNC clock edges through
  // a queue. The sequencer is described as a mode (0 idle, 1 left, 2 right,
  // 3 hazard) plus a sweep phase from 1 to 3.
  logic [3:0] hq[$];
  int m_mode = 0;
  int m_ph = 0;

  always @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      m_mode = 0;
      m_ph = 0;
      hq.delete();
      for (int k = 0; k <= SYNC; k++) hq.push_back(4'b0);
    end else begin
      logic [3:0] s;
      logic [3:0] p;
      s = hq[SYNC-1];
      p = hq[SYNC];
      if (s[3] && !p[3]) begin
        case (m_mode)
          0: begin
            if (s[0] || (s[2] && s[1])) m_mode = 3;
            else if (s[2]) begin m_mode = 1; m_ph = 1; end
            else if (s[1]) begin m_mode = 2; m_ph = 1; end
          end
          1, 2: begin
            if (s[0]) begin m_mode = 3; m_ph = 0; end
            else if (m_ph == 3) begin m_mode = 0; m_ph = 0; end
            else m_ph = m_ph + 1;
          end
          default: begin m_mode = 0; m_ph = 0; end
        endcase
      end
      hq.push_front({step_clk, left, right, hazard});
      void'(hq.pop_back());
    end
  end

  function automatic logic [9:0] model_vec();
    logic [2:0] ll, lr, st;
    ll = 3'b000; lr = 3'b000; st = 3'd0;
    if (m_mode == 1) begin ll = 3'((1 << m_ph) - 1); st = 3'(m_ph); end
    if (m_mode == 2) begin lr = 3'((1 << m_ph) - 1); st = 3'(3 + m_ph); end
    if (m_mode == 3) begin ll = 3'b111; lr = 3'b111; st = 3'd7; end
    return {ll, lr, st, (m_mode != 0)};
  endfunction

  function automatic logic [9:0] spec_vec(logic [2:0] ll, logic [2:0] lr, logic [2:0] st);
    return {ll, lr, st, (st != 3'd0)};
  endfunction

  task automatic wait_neg(int n);
    repeat (n) @(negedge clk_in);
  endtask

  // One rising edge of step_clk followed by enough time to settle.
  task automatic step_edge();
    step_clk = 1'b1;
    wait_neg(6);
    step_clk = 1'b0;
    wait_neg(4);
  endtask

  task automatic test_reset();
    logic [9:0] got;
    rst = 1'b0;
    left = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      step_clk = ~step_clk;
      got = {lights_l, lights_r, state_dbg, busy};
      if (got !== 10'd0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %b, expected %b", i, got, 10'd0);
      end
      checks++;
    end
    @(negedge clk_in);
    step_clk = 1'b0;
    wait_neg(2);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      got = {lights_l, lights_r, state_dbg, busy};
      if (got !== 10'd0) begin
        errors++;
        $display("FAIL reset_release_idle cycle %0d: got %b, expected %b", i, got, 10'd0);
      end
      checks++;
    end
    left = 1'b0;
    wait_neg(4);
  endtask

  task automatic test_tick_gen();
    int first_k;
    int changes;
    logic [2:0] prev;
    left = 1'b1;
    wait_neg(4);
    first_k = -1;
    changes = 0;
    prev = state_dbg;
    step_clk = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk_in);
      #1;
      if (state_dbg !== prev) begin
        changes++;
        if (first_k < 0) first_k = k;
      end
      prev = state_dbg;
    end
    if (first_k !== SYNC + 1) begin
      errors++;
      $display("FAIL tick_latency: got edge %0d, expected edge %0d", first_k, SYNC + 1);
    end
    checks++;
    if (changes !== 1) begin
      errors++;
      $display("FAIL tick_once: got %0d state changes, expected 1", changes);
    end
    checks++;
    @(negedge clk_in);
    step_clk = 1'b0;
    left = 1'b0;
    wait_neg(10);
    if (state_dbg !== 3'd1) begin
      errors++;
      $display("FAIL tick_falling_edge: got state %0d, expected 1", state_dbg);
    end
    checks++;
    repeat (3) step_edge();
    if (state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL tick_return_idle: got state %0d, expected 0", state_dbg);
    end
    checks++;
  endtask

  task automatic test_left_sweep();
    logic [2:0] exp_l[5] = '{3'b001, 3'b011, 3'b111, 3'b000, 3'b001};
    logic [2:0] exp_s[5] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd1};
    logic [9:0] got, exp;
    left = 1'b1;
    wait_neg(4);
    for (int i = 0; i < 5; i++) begin
      step_edge();
      got = {lights_l, lights_r, state_dbg, busy};
      exp = spec_vec(exp_l[i], 3'b000, exp_s[i]);
      if (got !== exp) begin
        errors++;
        $display("FAIL left_sweep step %0d: got %b, expected %b", i + 1, got, exp);
      end
      checks++;
    end
    left = 1'b0;
    repeat (3) step_edge();
    if (state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL left_sweep_end: got state %0d, expected 0", state_dbg);
    end
    checks++;
  endtask

  task automatic test_mid_drop();
    logic [2:0] exp_r[4] = '{3'b001, 3'b011, 3'b111, 3'b000};
    logic [2:0] exp_s[4] = '{3'd4, 3'd5, 3'd6, 3'd0};
    logic [9:0] got, exp;
    right = 1'b1;
    wait_neg(4);
    for (int i = 0; i < 4; i++) begin
      step_edge();
      if (i == 0) right = 1'b0;
      got = {lights_l, lights_r, state_dbg, busy};
      exp = spec_vec(3'b000, exp_r[i], exp_s[i]);
      if (got !== exp) begin
        errors++;
        $display("FAIL mid_drop step %0d: got %b, expected %b", i + 1, got, exp);
      end
      checks++;
    end
  endtask

  task automatic test_hazard_preempt();
    logic [9:0] got, exp;
    left = 1'b1;
    wait_neg(4);
    step_edge();
    step_edge();
    got = {lights_l, lights_r, state_dbg, busy};
    exp = spec_vec(3'b011, 3'b000, 3'd2);
    if (got !== exp) begin
      errors++;
      $display("FAIL hazard_setup_L2: got %b, expected %b", got, exp);
    end
    checks++;
    left = 1'b0;
    hazard = 1'b1;
    wait_neg(4);
    for (int i = 0; i < 3; i++) begin
      step_edge();
      got = {lights_l, lights_r, state_dbg, busy};
      exp = (i == 1) ? spec_vec(3'b000, 3'b000, 3'd0) : spec_vec(3'b111, 3'b111, 3'd7);
      if (got !== exp) begin
        errors++;
        $display("FAIL hazard_blink step %0d: got %b, expected %b", i + 1, got, exp);
      end
      checks++;
    end
    hazard = 1'b0;
    wait_neg(4);
    step_edge();
    if (state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL hazard_exit: got state %0d, expected 0", state_dbg);
    end
    checks++;
  endtask

  task automatic test_async_reset();
    logic [9:0] got, exp;
    right = 1'b1;
    wait_neg(4);
    repeat (3) step_edge();
    if (state_dbg !== 3'd6) begin
      errors++;
      $display("FAIL async_setup_R3: got state %0d, expected 6", state_dbg);
    end
    checks++;
    #3;
    rst = 1'b0;
    #0.5;
    got = {lights_l, lights_r, state_dbg, busy};
    if (got !== 10'd0) begin
      errors++;
      $display("FAIL async_reset_immediate: got %b, expected %b", got, 10'd0);
    end
    checks++;
    #0.5;
    rst = 1'b1;
    wait_neg(4);
    step_edge();
    got = {lights_l, lights_r, state_dbg, busy};
    exp = spec_vec(3'b000, 3'b001, 3'd4);
    if (got !== exp) begin
      errors++;
      $display("FAIL async_restart_R1: got %b, expected %b", got, exp);
    end
    checks++;
    right = 1'b0;
    repeat (3) step_edge();
  endtask

  task automatic test_random();
    logic [9:0] got, exp;
    int errs_here;
    errs_here = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_in);
      got = {lights_l, lights_r, state_dbg, busy};
      exp = model_vec();
      if (got !== exp) begin
        errors++;
        errs_here++;
        if (errs_here <= 10)
          $display("FAIL random cycle %0d: got %b, expected %b", i, got, exp);
      end
      checks++;
      if ($urandom_range(0, 7) == 0) step_clk = ~step_clk;
      if ($urandom_range(0, 39) == 0) left = ~left;
      if ($urandom_range(0, 39) == 0) right = ~right;
      if ($urandom_range(0, 59) == 0) hazard = ~hazard;
      if ($urandom_range(0, 599) == 0) begin
        #3;
        rst = 1'b0;
        #1;
        rst = 1'b1;
      end
    end
    step_clk = 1'b0;
    left = 1'b0;
    right = 1'b0;
    hazard = 1'b0;
    wait_neg(4);
  endtask

  initial begin
    #1 rst = 1'b0;
    test_reset();
    test_tick_gen();
    test_left_sweep();
    test_mid_drop();
    test_hazard_preempt();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
